// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe: pipelined extended-Hamming SECDED codec.
// Encode path is registered (latency 1). Decode is two stages (syndrome, then
// classify/correct) with valid/ready backpressure. Saturating SEC/DED counters
// and a sticky first-DED syndrome are updated on the output handshake.
// Optional build macro ECC_ERR_INJECT_EN adds i_inj_mask, which is XORed onto
// the incoming codeword at stage-1 capture for fault injection.
module hamming_secded_pipe #(
  parameter int K     = 8,
  parameter int CNT_W = 16,
  // smallest m with 2^m >= m+K+1
  localparam int M = (K + 4  <= 8)     ? 3  :
                     (K + 5  <= 16)    ? 4  :
                     (K + 6  <= 32)    ? 5  :
                     (K + 7  <= 64)    ? 6  :
                     (K + 8  <= 128)   ? 7  :
                     (K + 9  <= 256)   ? 8  :
                     (K + 10 <= 512)   ? 9  :
                     (K + 11 <= 1024)  ? 10 :
                     (K + 12 <= 2048)  ? 11 :
                     (K + 13 <= 4096)  ? 12 :
                     (K + 14 <= 8192)  ? 13 :
                     (K + 15 <= 16384) ? 14 :
                     (K + 16 <= 32768) ? 15 : 16,
  localparam int N = K + M + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enc_valid,
  input  logic [K-1:0]     i_enc_data,
  output logic             o_enc_valid,
  output logic [N-1:0]     o_enc_code,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  input  logic [N-1:0]     i_din_code,
`ifdef ECC_ERR_INJECT_EN
  input  logic [N-1:0]     i_inj_mask,
`endif
  output logic             o_dout_valid,
  input  logic             i_dout_ready,
  output logic [K-1:0]     o_dout_data,
  output logic             o_dout_sec,
  output logic             o_dout_ded,
  output logic [M-1:0]     o_dout_syndrome,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_sec_cnt,
  output logic [CNT_W-1:0] o_ded_cnt,
  output logic             o_ded_sticky,
  output logic [M-1:0]     o_ded_first_syn
);

  localparam logic [M-1:0] SMAX = M'(N - 1);
  localparam logic [N-1:0] BIT0 = {{(N-1){1'b0}}, 1'b1};

  // Place data in non-power-of-two positions, then build each check bit and
  // finally the overall parity over positions 1..N-1.
  function automatic logic [N-1:0] enc_fn(input logic [K-1:0] d);
    logic [N-1:0] c;
    int di;
    c  = '0;
    di = 0;
    for (int p = 1; p < N; p++)
      if ((p & (p - 1)) != 0) begin
        c[p] = d[di];
        di++;
      end
    for (int j = 0; j < M; j++)
      for (int p = 1; p < N; p++)
        if (p[j] && (p != (1 << j))) c[1 << j] = c[1 << j] ^ c[p];
    c[0] = ^c[N-1:1];
    return c;
  endfunction

  // XOR of the indices of all set bits in positions 1..N-1.
  function automatic logic [M-1:0] syn_fn(input logic [N-1:0] c);
    logic [M-1:0] s;
    s = '0;
    for (int p = 1; p < N; p++)
      if (c[p]) s = s ^ p[M-1:0];
    return s;
  endfunction

  // Gather data bits back out of the non-power-of-two positions.
  function automatic logic [K-1:0] ext_fn(input logic [N-1:0] c);
    logic [K-1:0] d;
    int di;
    d  = '0;
    di = 0;
    for (int p = 1; p < N; p++)
      if ((p & (p - 1)) != 0) begin
        d[di] = c[p];
        di++;
      end
    return d;
  endfunction

  // Encode register: code only moves on a request, valid follows request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_enc_valid <= 1'b0;
      o_enc_code  <= '0;
    end else begin
      o_enc_valid <= i_enc_valid;
      if (i_enc_valid) o_enc_code <= enc_fn(i_enc_data);
    end
  end

  logic         s1_v, s1_pe;
  logic [N-1:0] s1_code;
  logic [M-1:0] s1_syn;
  logic         adv1, adv2, out_hs;
  logic [N-1:0] din;

`ifdef ECC_ERR_INJECT_EN
  assign din = i_din_code ^ i_inj_mask;
`else
  assign din = i_din_code;
`endif

  assign adv2        = !o_dout_valid || i_dout_ready;
  assign adv1        = !s1_v || adv2;
  assign o_din_ready = adv1;
  assign out_hs      = o_dout_valid && i_dout_ready;

  // Stage 1: capture codeword with its syndrome and overall parity.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v    <= 1'b0;
      s1_pe   <= 1'b0;
      s1_code <= '0;
      s1_syn  <= '0;
    end else if (adv1) begin
      s1_v <= i_din_valid;
      if (i_din_valid) begin
        s1_code <= din;
        s1_syn  <= syn_fn(din);
        s1_pe   <= ^din;
      end
    end
  end

  logic [N-1:0] fix;
  logic         c_sec, c_ded;

  // Classify stage-1 word; only an in-range syndrome with odd parity flips a
  // bit. Syndrome 0 with odd parity means the overall parity bit itself broke.
  always_comb begin
    fix   = s1_code;
    c_sec = 1'b0;
    c_ded = 1'b0;
    if (s1_pe) begin
      if (s1_syn <= SMAX) begin
        c_sec = 1'b1;
        if (s1_syn != '0) fix = s1_code ^ (BIT0 << s1_syn);
      end else begin
        c_ded = 1'b1;
      end
    end else if (s1_syn != '0) begin
      c_ded = 1'b1;
    end
  end

  // Stage 2: output register, frozen while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dout_valid    <= 1'b0;
      o_dout_data     <= '0;
      o_dout_sec      <= 1'b0;
      o_dout_ded      <= 1'b0;
      o_dout_syndrome <= '0;
    end else if (adv2) begin
      o_dout_valid    <= s1_v;
      o_dout_data     <= ext_fn(fix);
      o_dout_sec      <= c_sec;
      o_dout_ded      <= c_ded;
      o_dout_syndrome <= s1_syn;
    end
  end

  // Error logging on accepted output words; clear wins over any update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sec_cnt       <= '0;
      o_ded_cnt       <= '0;
      o_ded_sticky    <= 1'b0;
      o_ded_first_syn <= '0;
    end else if (i_cnt_clr) begin
      o_sec_cnt       <= '0;
      o_ded_cnt       <= '0;
      o_ded_sticky    <= 1'b0;
      o_ded_first_syn <= '0;
    end else if (out_hs) begin
      if (o_dout_sec && (o_sec_cnt != '1)) o_sec_cnt <= o_sec_cnt + 1'b1;
      if (o_dout_ded && (o_ded_cnt != '1)) o_ded_cnt <= o_ded_cnt + 1'b1;
      if (o_dout_ded && !o_ded_sticky) begin
        o_ded_sticky    <= 1'b1;
        o_ded_first_syn <= o_dout_syndrome;
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Bench for hamming_secded_pipe (K=8, CNT_W=4): encode sweep, hand-built error
// table, backpressure, counter saturation/clear, random traffic, mid-stream reset.
module tb_hamming_secded_pipe;
  localparam int K = 8, CNT_W = 4, M = 4, N = 13;
  localparam int CMAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [N-1:0] code;
    logic [K-1:0] data;
    logic         sec;
    logic         ded;
    logic [M-1:0] syn;
  } vec_t;

  logic             i_clk, i_rst_n;
  logic             i_enc_valid;
  logic [K-1:0]     i_enc_data;
  logic             o_enc_valid;
  logic [N-1:0]     o_enc_code;
  logic             i_din_valid;
  logic             o_din_ready;
  logic [N-1:0]     i_din_code;
  logic             o_dout_valid;
  logic             i_dout_ready;
  logic [K-1:0]     o_dout_data;
  logic             o_dout_sec, o_dout_ded;
  logic [M-1:0]     o_dout_syndrome;
  logic             i_cnt_clr;
  logic [CNT_W-1:0] o_sec_cnt, o_ded_cnt;
  logic             o_ded_sticky;
  logic [M-1:0]     o_ded_first_syn;

  hamming_secded_pipe #(.K(K), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_enc_valid(i_enc_valid), .i_enc_data(i_enc_data),
    .o_enc_valid(o_enc_valid), .o_enc_code(o_enc_code),
    .i_din_valid(i_din_valid), .o_din_ready(o_din_ready), .i_din_code(i_din_code),
    .o_dout_valid(o_dout_valid), .i_dout_ready(i_dout_ready),
    .o_dout_data(o_dout_data), .o_dout_sec(o_dout_sec), .o_dout_ded(o_dout_ded),
    .o_dout_syndrome(o_dout_syndrome), .i_cnt_clr(i_cnt_clr),
    .o_sec_cnt(o_sec_cnt), .o_ded_cnt(o_ded_cnt),
    .o_ded_sticky(o_ded_sticky), .o_ded_first_syn(o_ded_first_syn)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int           n_chk, n_pass;
  vec_t         sb[$];
  int           dpos[K];
  int           m_sec, m_ded;
  logic         m_sticky;
  logic [M-1:0] m_syn;
  bit           rnd;
  logic [N-1:0] codes[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference encoder: check bit j is bit j of the XOR of indices of set data bits.
  function automatic logic [N-1:0] ref_encode(input logic [K-1:0] d);
    logic [N-1:0] c;
    int s;
    c = '0;
    s = 0;
    for (int i = 0; i < K; i++) begin
      c[dpos[i]] = d[i];
      if (d[i]) s = s ^ dpos[i];
    end
    for (int j = 0; j < M; j++) c[1 << j] = s[j];
    c[0] = ^c[N-1:1];
    return c;
  endfunction

  function automatic vec_t ref_decode(input logic [N-1:0] c);
    vec_t r;
    int s;
    logic pe;
    logic [N-1:0] f;
    s = 0;
    for (int p = 1; p < N; p++) if (c[p]) s = s ^ p;
    pe = ^c;
    f = c;
    r.code = c; r.sec = 1'b0; r.ded = 1'b0; r.syn = s[M-1:0];
    if (pe && s <= N - 1) begin
      r.sec = 1'b1;
      if (s != 0) f[s] = ~f[s];
    end else if (pe || s != 0) begin
      r.ded = 1'b1;
    end
    for (int i = 0; i < K; i++) r.data[i] = f[dpos[i]];
    return r;
  endfunction

  // Output scoreboard and counter model, evaluated once per falling edge.
  task automatic monitor();
    vec_t e;
    bit got;
    got = 1'b0;
    if (o_dout_valid && i_dout_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 32'(o_dout_data), 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        got = 1'b1;
        chk("dout_word", 32'({o_dout_data, o_dout_sec, o_dout_ded, o_dout_syndrome}),
            32'({e.data, e.sec, e.ded, e.syn}));
      end
    end
    if (i_cnt_clr) begin
      m_sec = 0; m_ded = 0; m_sticky = 1'b0; m_syn = '0;
    end else if (got) begin
      if (e.sec && m_sec < CMAX) m_sec++;
      if (e.ded && m_ded < CMAX) m_ded++;
      if (e.ded && !m_sticky) begin m_sticky = 1'b1; m_syn = e.syn; end
    end
  endtask

  task automatic neg(); @(negedge i_clk); monitor(); endtask
  task automatic pos(); @(posedge i_clk); #1; endtask
  task automatic cyc(); neg(); pos(); endtask

  // Offer one word; waits (bounded) for acceptance. Starts/ends 1 unit after a rising edge.
  task automatic send(input logic [N-1:0] code, input vec_t e);
    int t;
    t = 0;
    i_din_valid = 1'b1;
    i_din_code  = code;
    forever begin
      if (rnd) i_dout_ready = 1'($urandom_range(0, 1));
      neg();
      if (o_din_ready || t > 50) break;
      pos();
      t++;
    end
    if (o_din_ready) sb.push_back(e);
    else chk("send_timeout", 32'(o_din_ready), 32'd1);
    pos();
    i_din_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    i_dout_ready = 1'b1;
    while (sb.size() != 0 && t < 100) begin cyc(); t++; end
    cyc(); cyc();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_cnt(input string name);
    chk({name, "_sec_cnt"}, 32'(o_sec_cnt), 32'(m_sec));
    chk({name, "_ded_cnt"}, 32'(o_ded_cnt), 32'(m_ded));
    chk({name, "_sticky"}, 32'(o_ded_sticky), 32'(m_sticky));
    chk({name, "_first_syn"}, 32'(o_ded_first_syn), 32'(m_syn));
  endtask

  // One accepted word must show up exactly two rising edges after acceptance.
  task automatic lat_check(input string name);
    vec_t e;
    logic [K-1:0] d;
    d = 8'($urandom);
    e = '{code: ref_encode(d), data: d, sec: 1'b0, ded: 1'b0, syn: '0};
    i_dout_ready = 1'b1;
    send(ref_encode(d), e);
    chk({name, "_lat1"}, 32'(o_dout_valid), 32'd0);
    cyc();
    chk({name, "_lat2"}, 32'(o_dout_valid), 32'd1);
    drain();
  endtask

  initial begin
    vec_t tbl[7];
    vec_t e;
    logic [N-1:0] w[3];
    logic [N-1:0] mask;
    logic [31:0] hold;
    logic [K-1:0] d;
    int t, di;

    n_chk = 0; n_pass = 0; rnd = 1'b0;
    m_sec = 0; m_ded = 0; m_sticky = 1'b0; m_syn = '0;
    di = 0;
    for (int p = 1; p < N; p++) if ((p & (p - 1)) != 0) begin dpos[di] = p; di++; end

    // code, data, sec, ded, syn -- all built around the all-zero codeword of 0x00
    tbl[0] = '{13'h0020, 8'h00, 1'b1, 1'b0, 4'd5};
    tbl[1] = '{13'h0001, 8'h00, 1'b1, 1'b0, 4'd0};
    tbl[2] = '{13'h0048, 8'h05, 1'b0, 1'b1, 4'd5};
    tbl[3] = '{13'h0006, 8'h00, 1'b0, 1'b1, 4'd3};
    tbl[4] = '{13'h0121, 8'h02, 1'b0, 1'b1, 4'd13};
    tbl[5] = '{13'h1000, 8'h00, 1'b1, 1'b0, 4'd12};
    tbl[6] = '{13'h0010, 8'h00, 1'b1, 1'b0, 4'd4};

    i_rst_n = 1'b1; i_enc_valid = 1'b0; i_enc_data = '0; i_din_valid = 1'b0;
    i_din_code = '0; i_dout_ready = 1'b1; i_cnt_clr = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_enc_valid", 32'(o_enc_valid), 32'd0);
    chk("rst_enc_code", 32'(o_enc_code), 32'd0);
    chk("rst_dout_valid", 32'(o_dout_valid), 32'd0);
    chk("rst_din_ready", 32'(o_din_ready), 32'd1);
    chk("rst_dout_data", 32'(o_dout_data), 32'd0);
    chk_cnt("rst");
    pos(); pos();
    i_rst_n = 1'b1;
    lat_check("start");

    // Encode sweep
    for (int v = 0; v < 256; v++) begin
      i_enc_valid = 1'b1;
      i_enc_data  = 8'(v);
      cyc();
      chk("enc_valid", 32'(o_enc_valid), 32'd1);
      chk("enc_code", 32'(o_enc_code), 32'(ref_encode(8'(v))));
      codes[v] = o_enc_code;
    end
    i_enc_valid = 1'b0;
    i_enc_data  = 8'hA5;
    cyc();
    chk("enc_idle_valid", 32'(o_enc_valid), 32'd0);
    chk("enc_hold_code", 32'(o_enc_code), 32'(ref_encode(8'hFF)));

    // Round trip of every encoded word, back to back
    for (int v = 0; v < 256; v++) begin
      e = '{code: codes[v], data: 8'(v), sec: 1'b0, ded: 1'b0, syn: '0};
      send(codes[v], e);
    end
    drain();
    chk_cnt("clean");

    // Hand-built error table
    for (int i = 0; i < 7; i++) send(tbl[i].code, tbl[i]);
    drain();
    chk_cnt("table");
    chk("table_first_syn_5", 32'(o_ded_first_syn), 32'd5);

    // Backpressure: two words fill the pipe, third is held off
    for (int i = 0; i < 3; i++) w[i] = ref_encode(8'($urandom)) ^ (13'h1 << $urandom_range(0, N - 1));
    i_dout_ready = 1'b0;
    send(w[0], ref_decode(w[0]));
    send(w[1], ref_decode(w[1]));
    i_din_valid = 1'b1;
    i_din_code  = w[2];
    neg();
    chk("bp_ready_low", 32'(o_din_ready), 32'd0);
    chk("bp_valid", 32'(o_dout_valid), 32'd1);
    hold = 32'({o_dout_data, o_dout_sec, o_dout_ded, o_dout_syndrome});
    for (int i = 0; i < 3; i++) begin
      pos(); neg();
      chk("bp_hold", 32'({o_dout_data, o_dout_sec, o_dout_ded, o_dout_syndrome}), hold);
      chk("bp_ready_hold", 32'(o_din_ready), 32'd0);
    end
    pos();
    i_dout_ready = 1'b1;
    neg();
    chk("bp_release_ready", 32'(o_din_ready), 32'd1);
    if (o_din_ready) sb.push_back(ref_decode(w[2]));
    pos();
    i_din_valid = 1'b0;
    drain();

    // 20 single-bit errors push the SEC counter into saturation
    for (int i = 0; i < 20; i++) begin
      mask = ref_encode(8'($urandom)) ^ (13'h1 << $urandom_range(0, N - 1));
      send(mask, ref_decode(mask));
    end
    drain();
    chk_cnt("sat");
    chk("sat_sec_15", 32'(o_sec_cnt), 32'(CMAX));

    // Clear coinciding with an SEC handshake
    i_dout_ready = 1'b0;
    mask = ref_encode(8'h3C) ^ 13'h0200;
    send(mask, ref_decode(mask));
    t = 0;
    while (!o_dout_valid && t < 10) begin cyc(); t++; end
    chk("clr_word_ready", 32'(o_dout_valid), 32'd1);
    i_dout_ready = 1'b1;
    i_cnt_clr    = 1'b1;
    cyc();
    i_cnt_clr = 1'b0;
    chk_cnt("clr");
    chk("clr_sec_zero", 32'(o_sec_cnt), 32'd0);

    // Random traffic with 0..3 bit errors and random stalls
    rnd = 1'b1;
    for (int i = 0; i < 300; i++) begin
      mask = '0;
      t = $urandom_range(0, 3);
      while ($countones(mask) < t) mask = mask | (13'h1 << $urandom_range(0, N - 1));
      d = 8'($urandom);
      send(ref_encode(d) ^ mask, ref_decode(ref_encode(d) ^ mask));
      if ($urandom_range(0, 3) == 0) begin
        i_dout_ready = 1'($urandom_range(0, 1));
        cyc();
      end
    end
    rnd = 1'b0;
    drain();
    chk_cnt("rand");

    // Reset with both stages occupied
    i_dout_ready = 1'b0;
    send(ref_encode(8'h11), ref_decode(ref_encode(8'h11)));
    send(ref_encode(8'h22), ref_decode(ref_encode(8'h22)));
    chk("mid_full_valid", 32'(o_dout_valid), 32'd1);
    chk("mid_full_ready", 32'(o_din_ready), 32'd0);
    i_rst_n = 1'b0;
    #1;
    sb.delete();
    m_sec = 0; m_ded = 0; m_sticky = 1'b0; m_syn = '0;
    chk("mid_rst_valid", 32'(o_dout_valid), 32'd0);
    chk("mid_rst_ready", 32'(o_din_ready), 32'd1);
    chk("mid_rst_data", 32'(o_dout_data), 32'd0);
    chk_cnt("mid_rst");
    pos(); pos();
    i_rst_n = 1'b1;
    lat_check("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
